// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline types for the hazard controller (the "pipes" package).
//   creg_addr_t    : architectural register index (5 bits, X0..X30 plus XZR)
//   fetch_state_t  : state encoding of the fetch-response FSM
//   CREG_AW        : register address width
//   ZERO_REG_DEF   : index of XZR, which never creates a hazard
package hazard_ctrl_pkg;

  localparam int CREG_AW      = 5;
  localparam int ZERO_REG_DEF = 31;

  typedef logic [CREG_AW-1:0] creg_addr_t;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_WAIT = 2'd1,
    F_HOLD = 2'd2,
    F_DROP = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/hazard_match.sv
// NSRC-wide source/destination comparator.
// A source hits when it is used, is not the zero register and equals dst_i.
//   srcs_i  in  NSRC*AW  packed source indices, source i at [i*AW +: AW]
//   used_i  in  NSRC     per-source valid
//   dst_i   in  AW       destination index to compare against
//   en_i    in  1        qualifies the whole check (e.g. "producer is a load")
//   hit_o   out 1        en_i and at least one source hit
module hazard_match #(
  parameter int NSRC     = 3,
  parameter int AW       = 5,
  parameter int ZERO_REG = 31
) (
  input  logic [NSRC*AW-1:0] srcs_i,
  input  logic [NSRC-1:0]    used_i,
  input  logic [AW-1:0]      dst_i,
  input  logic               en_i,
  output logic               hit_o
);

  localparam logic [AW-1:0] ZR = AW'(ZERO_REG);

  logic [NSRC-1:0] src_hit;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    assign src_hit[i] = used_i[i] &&
                        (srcs_i[i*AW +: AW] == dst_i) &&
                        (srcs_i[i*AW +: AW] != ZR);
  end

  assign hit_o = en_i & (|src_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage F/D/E/M/W core.
// Decodes data-memory, multi-cycle execute and load-use hazards into
// stall/flush strobes, honours E-stage redirects, and runs a fetch-response
// FSM with a one-word hold buffer that feeds the instruction word to D.
//
// Optional feature: define HAZARD_PERF_EN to add four 32-bit stall-cause
// counters (perf_dstall, perf_exstall, perf_ldstall, perf_fetch).
//
// Ports
//   clk, reset                 core clock, synchronous active-high reset
//   srcD/srcE, *_used          D/E source registers and per-source valids
//   br_useD                    D resolves a branch and needs operands in D
//   dstE, dstM                 destination registers in E and M
//   regwriteE, memtoregE/M     E writes a reg; E/M hold a load
//   exbusyE                    multi-cycle execute unit busy
//   redirectE                  E resolved a redirect
//   ireq_valid, iresp_*        ibus request outstanding / response strobe+data
//   dreq_valid, dresp_data_ok  dbus request outstanding / response strobe
//   stallF..M, flushD..W       stage hold / bubble strobes
//   ireq_en                    fetch may issue a new request
//   instD, instD_valid         instruction word for D
//
// Fetch FSM
//   state  | meaning
//   F_IDLE | no ibus response expected
//   F_WAIT | request issued, response pending
//   F_HOLD | response captured while D stalled; buffer drives instD
//   F_DROP | redirect killed a pending request; next response is discarded
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int NSRC     = 3,
  parameter int AW       = CREG_AW,
  parameter int IW       = 32,
  parameter int ZERO_REG = ZERO_REG_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NSRC*AW-1:0] srcD,
  input  logic [NSRC-1:0]    srcD_used,
  input  logic [NSRC*AW-1:0] srcE,
  input  logic [NSRC-1:0]    srcE_used,
  input  logic               br_useD,
  input  logic [AW-1:0]      dstE,
  input  logic [AW-1:0]      dstM,
  input  logic               regwriteE,
  input  logic               memtoregE,
  input  logic               memtoregM,
  input  logic               exbusyE,
  input  logic               redirectE,
  input  logic               ireq_valid,
  input  logic               iresp_data_ok,
  input  logic [IW-1:0]      iresp_data,
  input  logic               dreq_valid,
  input  logic               dresp_data_ok,
  output logic               stallF,
  output logic               stallD,
  output logic               stallE,
  output logic               stallM,
  output logic               flushD,
  output logic               flushE,
  output logic               flushM,
  output logic               flushW,
  output logic               ireq_en,
  output logic               instD_valid,
  output logic [IW-1:0]      instD
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]        perf_dstall,
  output logic [31:0]        perf_exstall,
  output logic [31:0]        perf_ldstall,
  output logic [31:0]        perf_fetch
`endif
);

  logic hit_de_load, hit_de_br, hit_dm_br, hit_em;
  logic dstall, exstall, lestall, ldstall_raw, ldstall;
  logic stall_e, stall_d, redir, fetch_stall, bypass, run;

  fetch_state_t  state_q, state_d;
  logic [IW-1:0] buf_q, buf_d;

  hazard_match #(.NSRC(NSRC), .AW(AW), .ZERO_REG(ZERO_REG)) u_match_de_load (
    .srcs_i(srcD), .used_i(srcD_used), .dst_i(dstE),
    .en_i(memtoregE), .hit_o(hit_de_load)
  );

  hazard_match #(.NSRC(NSRC), .AW(AW), .ZERO_REG(ZERO_REG)) u_match_de_br (
    .srcs_i(srcD), .used_i(srcD_used), .dst_i(dstE),
    .en_i(br_useD & regwriteE), .hit_o(hit_de_br)
  );

  hazard_match #(.NSRC(NSRC), .AW(AW), .ZERO_REG(ZERO_REG)) u_match_dm_br (
    .srcs_i(srcD), .used_i(srcD_used), .dst_i(dstM),
    .en_i(br_useD & memtoregM), .hit_o(hit_dm_br)
  );

  hazard_match #(.NSRC(NSRC), .AW(AW), .ZERO_REG(ZERO_REG)) u_match_em (
    .srcs_i(srcE), .used_i(srcE_used), .dst_i(dstM),
    .en_i(memtoregM), .hit_o(hit_em)
  );

  assign run         = ~reset;
  assign dstall      = dreq_valid & ~dresp_data_ok;
  assign exstall     = exbusyE & ~dstall;
  assign lestall     = hit_em;
  assign ldstall_raw = hit_de_load | hit_de_br | hit_dm_br;

  assign stall_e = dstall | exstall | lestall;
  assign redir   = redirectE & ~stall_e;
  // An accepted redirect kills the instruction in D, so a load-use stall
  // raised by that wrong-path instruction is moot and must not hold D
  // against the flush.
  assign ldstall = ldstall_raw & ~redir;
  assign stall_d = stall_e | ldstall;

  assign fetch_stall = ((state_q == F_WAIT) & ~iresp_data_ok) |
                       (state_q == F_DROP);

  assign stallF = run & (stall_d | fetch_stall);
  assign stallD = run & stall_d;
  assign stallE = run & stall_e;
  assign stallM = run & dstall;
  assign flushW = run & dstall;
  assign flushM = run & (exstall | lestall) & ~dstall;
  assign flushE = run & ((ldstall & ~stall_e) | redir);
  assign flushD = run & redir & ~stall_d;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    bypass  = 1'b0;
    case (state_q)
      F_IDLE: begin
        if (ireq_valid) state_d = F_WAIT;
      end
      F_WAIT: begin
        if (redir) begin
          // A response in the same cycle is simply dropped.
          state_d = iresp_data_ok ? F_IDLE : F_DROP;
        end else if (iresp_data_ok) begin
          if (stall_d) begin
            buf_d   = iresp_data;
            state_d = F_HOLD;
          end else begin
            bypass  = 1'b1;
            state_d = F_IDLE;
          end
        end
      end
      F_HOLD: begin
        if (redir) begin
          buf_d   = '0;
          state_d = F_IDLE;
        end else if (!stall_d) begin
          state_d = F_IDLE;
        end
      end
      F_DROP: begin
        if (iresp_data_ok) state_d = F_IDLE;
      end
      default: state_d = F_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= F_IDLE;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
    end
  end

  assign ireq_en     = run & (state_q != F_HOLD);
  assign instD_valid = run & (bypass | (state_q == F_HOLD));
  assign instD       = (run & bypass) ? iresp_data : buf_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_dstall_q, perf_exstall_q, perf_ldstall_q, perf_fetch_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_dstall_q  <= '0;
      perf_exstall_q <= '0;
      perf_ldstall_q <= '0;
      perf_fetch_q   <= '0;
    end else begin
      perf_dstall_q  <= perf_dstall_q  + 32'(dstall);
      perf_exstall_q <= perf_exstall_q + 32'(exstall);
      perf_ldstall_q <= perf_ldstall_q + 32'(ldstall);
      perf_fetch_q   <= perf_fetch_q   + 32'(fetch_stall);
    end
  end

  assign perf_dstall  = perf_dstall_q;
  assign perf_exstall = perf_exstall_q;
  assign perf_ldstall = perf_ldstall_q;
  assign perf_fetch   = perf_fetch_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. Inputs change 1 ns after the rising edge,
// outputs are sampled mid-cycle. Strobes are compared as one byte:
// {stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW}.
module tb_hazard_ctrl;
  localparam int NSRC = 3;
  localparam int AW   = 5;
  localparam int IW   = 32;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [NSRC*AW-1:0] srcD, srcE;
  logic [NSRC-1:0]    srcD_used, srcE_used;
  logic               br_useD, regwriteE, memtoregE, memtoregM, exbusyE, redirectE;
  logic [AW-1:0]      dstE, dstM;
  logic               ireq_valid, iresp_data_ok, dreq_valid, dresp_data_ok;
  logic [IW-1:0]      iresp_data;
  logic               stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW;
  logic               ireq_en, instD_valid;
  logic [IW-1:0]      instD;
  logic [7:0]         strobes;
`ifdef HAZARD_PERF_EN
  logic [31:0]        perf_dstall, perf_exstall, perf_ldstall, perf_fetch;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign strobes = {stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW};

  hazard_ctrl #(.NSRC(NSRC), .AW(AW), .IW(IW), .ZERO_REG(31)) dut (
    .clk(clk), .reset(reset),
    .srcD(srcD), .srcD_used(srcD_used), .srcE(srcE), .srcE_used(srcE_used),
    .br_useD(br_useD), .dstE(dstE), .dstM(dstM),
    .regwriteE(regwriteE), .memtoregE(memtoregE), .memtoregM(memtoregM),
    .exbusyE(exbusyE), .redirectE(redirectE),
    .ireq_valid(ireq_valid), .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .dreq_valid(dreq_valid), .dresp_data_ok(dresp_data_ok),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
    .ireq_en(ireq_en), .instD_valid(instD_valid), .instD(instD)
`ifdef HAZARD_PERF_EN
    ,
    .perf_dstall(perf_dstall), .perf_exstall(perf_exstall),
    .perf_ldstall(perf_ldstall), .perf_fetch(perf_fetch)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    #4;
  endtask

  task automatic idle_inputs();
    srcD = '0; srcE = '0; srcD_used = '0; srcE_used = '0;
    br_useD = 0; regwriteE = 0; memtoregE = 0; memtoregM = 0;
    exbusyE = 0; redirectE = 0; dstE = '0; dstM = '0;
    ireq_valid = 0; iresp_data_ok = 0; iresp_data = '0;
    dreq_valid = 0; dresp_data_ok = 0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    next_cyc(); next_cyc(); mid();
    chk("rst_strobes", 32'(strobes), 32'h00);
    chk("rst_ireq_en", 32'(ireq_en), 0);
    chk("rst_instD_valid", 32'(instD_valid), 0);
    chk("rst_instD", instD, 0);
    next_cyc(); reset = 1'b0; mid();
    chk("idle_ireq_en", 32'(ireq_en), 1);
    chk("idle_strobes", 32'(strobes), 32'h00);

    // 1: load-use and branch-operand hazards, XZR and unused masking
    next_cyc(); memtoregE = 1; regwriteE = 1; dstE = 5'd3;
    srcD = {5'd0, 5'd3, 5'd0}; srcD_used = 3'b010; mid();
    chk("t1_ldstall", 32'(strobes), 32'hC4);
    next_cyc(); idle_inputs(); mid();
    chk("t1_release", 32'(strobes), 32'h00);
    next_cyc(); memtoregE = 1; regwriteE = 1; dstE = 5'd31;
    srcD = {5'd0, 5'd31, 5'd0}; srcD_used = 3'b010; mid();
    chk("t1_xzr", 32'(strobes), 32'h00);
    next_cyc(); dstE = 5'd3; srcD = {5'd0, 5'd3, 5'd0}; srcD_used = 3'b101; mid();
    chk("t1_unused_src", 32'(strobes), 32'h00);
    next_cyc(); idle_inputs(); br_useD = 1; regwriteE = 1; dstE = 5'd5;
    srcD = {5'd5, 5'd0, 5'd0}; srcD_used = 3'b100; mid();
    chk("t1_br_de", 32'(strobes), 32'hC4);
    next_cyc(); br_useD = 0; mid();
    chk("t1_no_br", 32'(strobes), 32'h00);
    next_cyc(); idle_inputs(); memtoregM = 1; dstM = 5'd7;
    srcE = {5'd7, 5'd0, 5'd0}; srcE_used = 3'b100; mid();
    chk("t1_lestall", 32'(strobes), 32'hE2);

    // 2: data-bus stall for 4 cycles
    next_cyc(); idle_inputs(); dreq_valid = 1;
    for (int i = 0; i < 4; i++) begin
      mid();
      chk($sformatf("t2_dstall_%0d", i), 32'(strobes), 32'hF1);
      next_cyc();
    end
    dresp_data_ok = 1; mid();
    chk("t2_resp", 32'(strobes), 32'h00);
`ifdef HAZARD_PERF_EN
    chk("t6_perf_dstall", perf_dstall, 4);
`endif

    // 3: response while D stalled is held until the stall drops
    next_cyc(); idle_inputs(); ireq_valid = 1; mid();
    chk("t3_idle_nostall", 32'(strobes), 32'h00);
    next_cyc(); ireq_valid = 0; mid();
    chk("t3_wait_stallF", 32'(strobes), 32'h80);
    chk("t3_wait_nv", 32'(instD_valid), 0);
    next_cyc(); iresp_data_ok = 1; iresp_data = 32'hD503201F;
    memtoregE = 1; dstE = 5'd3; srcD = {5'd0, 5'd3, 5'd0}; srcD_used = 3'b010; mid();
    chk("t3_capture_nv", 32'(instD_valid), 0);
    chk("t3_capture_strobes", 32'(strobes), 32'hC4);
    next_cyc(); iresp_data_ok = 0; iresp_data = '0; mid();
    chk("t3_hold_v", 32'(instD_valid), 1);
    chk("t3_hold_word", instD, 32'hD503201F);
    chk("t3_hold_ireq_en", 32'(ireq_en), 0);
    next_cyc(); mid();
    chk("t3_hold2_word", instD, 32'hD503201F);
    next_cyc(); memtoregE = 0; mid();
    chk("t3_release_v", 32'(instD_valid), 1);
    chk("t3_release_strobes", 32'(strobes), 32'h00);
    next_cyc(); mid();
    chk("t3_idle_v", 32'(instD_valid), 0);
    chk("t3_idle_ireq_en", 32'(ireq_en), 1);

    // bypass: response with no stall goes straight to D
    next_cyc(); idle_inputs(); ireq_valid = 1;
    next_cyc(); ireq_valid = 0; iresp_data_ok = 1; iresp_data = 32'h8B020020; mid();
    chk("byp_v", 32'(instD_valid), 1);
    chk("byp_word", instD, 32'h8B020020);
    chk("byp_strobes", 32'(strobes), 32'h00);
    next_cyc(); iresp_data_ok = 0; mid();
    chk("byp_after_v", 32'(instD_valid), 0);

    // 4: redirect with response pending -> drop the next response
    next_cyc(); idle_inputs(); ireq_valid = 1;
    next_cyc(); ireq_valid = 0; redirectE = 1; mid();
    chk("t4_redir_strobes", 32'(strobes), 32'h8C);
    next_cyc(); redirectE = 0; mid();
    chk("t4_drop_stallF", 32'(strobes), 32'h80);
    next_cyc(); iresp_data_ok = 1; iresp_data = 32'h12345678; mid();
    chk("t4_drop_nv", 32'(instD_valid), 0);
    chk("t4_drop_strobes", 32'(strobes), 32'h80);
    next_cyc(); iresp_data_ok = 0; mid();
    chk("t4_after_drop", 32'(strobes), 32'h00);
    // simultaneous response and redirect: word dropped, straight to idle
    next_cyc(); ireq_valid = 1;
    next_cyc(); ireq_valid = 0; redirectE = 1; iresp_data_ok = 1; iresp_data = 32'hAAAA5555; mid();
    chk("t4_sim_nv", 32'(instD_valid), 0);
    chk("t4_sim_strobes", 32'(strobes), 32'h0C);
    next_cyc(); redirectE = 0; iresp_data_ok = 0; mid();
    chk("t4_sim_idle", 32'(strobes), 32'h00);
    // redirect ignored while E is held
    next_cyc(); exbusyE = 1; redirectE = 1; mid();
    chk("t4_redir_blocked", 32'(strobes), 32'hE2);

    // 5: multi-cycle execute over a D/M branch-operand hazard
    next_cyc(); idle_inputs(); exbusyE = 1; br_useD = 1; memtoregM = 1; dstM = 5'd9;
    srcD = {5'd0, 5'd0, 5'd9}; srcD_used = 3'b001;
    for (int i = 0; i < 8; i++) begin
      mid();
      chk($sformatf("t5_exstall_%0d", i), 32'(strobes), 32'hE2);
      next_cyc();
    end
    exbusyE = 0; mid();
    chk("t5_ldstall_left", 32'(strobes), 32'hC4);

    // reset in the middle of a fetch: late response is ignored
    next_cyc(); idle_inputs(); ireq_valid = 1;
    next_cyc(); ireq_valid = 0; reset = 1; mid();
    chk("t7_rst_strobes", 32'(strobes), 32'h00);
    next_cyc(); reset = 0; iresp_data_ok = 1; iresp_data = 32'hCAFEF00D; mid();
    chk("t7_late_nv", 32'(instD_valid), 0);
    chk("t7_late_strobes", 32'(strobes), 32'h00);
`ifdef HAZARD_PERF_EN
    chk("t6_rst_dstall", perf_dstall, 0);
    chk("t6_rst_exstall", perf_exstall, 0);
    chk("t6_rst_ldstall", perf_ldstall, 0);
    chk("t6_rst_fetch", perf_fetch, 0);
`endif

    next_cyc(); idle_inputs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
